// File: rtl/alu_issue_stage_if.sv
// Bundle of decode-side, ALU-side and downstream signals of the ALU issue stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the producer holds its
// payload stable while valid is high and ready is low.
interface alu_issue_stage_if #(
   parameter int DW  = 32,
   parameter int RW  = 5,
   parameter int OPW = 5
);
   // decode -> stage
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] in_opc;
   logic [RW-1:0]  in_rs1;
   logic [RW-1:0]  in_rs2;
   logic [RW-1:0]  in_rd;
   logic [DW-1:0]  in_rs1_val;
   logic [DW-1:0]  in_rs2_val;
   logic [DW-1:0]  in_imm;
   // stage <-> combinational ALU
   logic [DW-1:0]  alu_inp1;
   logic [DW-1:0]  alu_inp2;
   logic [OPW-1:0] alu_opc;
   logic [DW-1:0]  alu_out;
   // stage -> MEM/WB
   logic           out_valid;
   logic           out_ready;
   logic [OPW-1:0] out_opc;
   logic [RW-1:0]  out_rd;
   logic           out_wr_en;
   logic [DW-1:0]  out_result;
   logic [DW-1:0]  out_store_data;

   // the issue stage itself
   modport slave (
      input  in_valid, in_opc, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val, in_imm,
      input  alu_out, out_ready,
      output in_ready, alu_inp1, alu_inp2, alu_opc,
      output out_valid, out_opc, out_rd, out_wr_en, out_result, out_store_data
   );

   // surrounding pipeline (decode, ALU, MEM/WB)
   modport master (
      output in_valid, in_opc, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val, in_imm,
      output alu_out, out_ready,
      input  in_ready, alu_inp1, alu_inp2, alu_opc,
      input  out_valid, out_opc, out_rd, out_wr_en, out_result, out_store_data
   );
endinterface

// File: rtl/alu_issue_stage.sv
// EX-side pipeline stage around an external combinational ALU.
// S1 (issue register) drives the ALU, S2 (result register) feeds MEM/WB.
// RAW hazards are resolved by forwarding from S1 (ALU output) and S2;
// a load result is not available here, so a dependent instruction waits.
module alu_issue_stage #(
   parameter int DW  = 32,
   parameter int RW  = 5,
   parameter int OPW = 5
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_stage_if.slave  io
);

   localparam logic [OPW-1:0] OPC_JUMP    = OPW'(8);
   localparam logic [OPW-1:0] OPC_LW      = OPW'(10);
   localparam logic [OPW-1:0] OPC_ILL_MIN = OPW'(14);

   // opcodes taking the immediate as operand 2
   function automatic logic uses_imm(input logic [OPW-1:0] opc);
      logic [31:0] o;
      o = 32'(opc);
      case (o)
         32'd2, 32'd3, 32'd10, 32'd11, 32'd12, 32'd13: uses_imm = 1'b1;
         default:                                     uses_imm = 1'b0;
      endcase
   endfunction

   // opcodes reading rs2 (for load-use detection)
   function automatic logic uses_rs2(input logic [OPW-1:0] opc);
      logic [31:0] o;
      o = 32'(opc);
      case (o)
         32'd0, 32'd1, 32'd4, 32'd5, 32'd6, 32'd7, 32'd9, 32'd11: uses_rs2 = 1'b1;
         default:                                                uses_rs2 = 1'b0;
      endcase
   endfunction

   // opcodes that write a destination register
   function automatic logic writes_rd(input logic [OPW-1:0] opc);
      logic [31:0] o;
      o = 32'(opc);
      case (o)
         32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
         32'd9, 32'd10, 32'd12, 32'd13: writes_rd = 1'b1;
         default:                       writes_rd = 1'b0;
      endcase
   endfunction

   // S1 issue register
   logic           s1_valid_q, s1_valid_d;
   logic [OPW-1:0] s1_opc_q,   s1_opc_d;
   logic [RW-1:0]  s1_rd_q,    s1_rd_d;
   logic           s1_wr_en_q, s1_wr_en_d;
   logic [DW-1:0]  s1_inp1_q,  s1_inp1_d;
   logic [DW-1:0]  s1_inp2_q,  s1_inp2_d;
   logic [DW-1:0]  s1_jmp_q,   s1_jmp_d;
   logic [DW-1:0]  s1_store_q, s1_store_d;
   // S2 result register
   logic           s2_valid_q,  s2_valid_d;
   logic [OPW-1:0] s2_opc_q,    s2_opc_d;
   logic [RW-1:0]  s2_rd_q,     s2_rd_d;
   logic           s2_wr_en_q,  s2_wr_en_d;
   logic [DW-1:0]  s2_result_q, s2_result_d;
   logic [DW-1:0]  s2_store_q,  s2_store_d;

   logic          s1_adv, s2_adv, accept, interlock, in_ready;
   logic          s1_fwd_ok, s2_fwd_ok, s1_lw, s2_lw, legal_ops;
   logic [DW-1:0] rs1_op, rs2_op;

   // handshake, hazard detection, operand select and next-state of S1/S2
   always_comb begin
      s2_adv = s2_valid_q & io.out_ready;
      s1_adv = s1_valid_q & (~s2_valid_q | io.out_ready);

      // a lw in flight blocks any consumer of its rd until it has left S2
      s1_lw = s1_valid_q & (s1_opc_q == OPC_LW) & (s1_rd_q != '0);
      s2_lw = s2_valid_q & (s2_opc_q == OPC_LW) & (s2_rd_q != '0);
      interlock = (s1_lw & (s1_rd_q == io.in_rs1)) | (s2_lw & (s2_rd_q == io.in_rs1)) |
                  (uses_rs2(io.in_opc) &
                   ((s1_lw & (s1_rd_q == io.in_rs2)) | (s2_lw & (s2_rd_q == io.in_rs2))));

      in_ready = ~rst & (~s1_valid_q | s1_adv) & ~interlock;
      accept   = io.in_valid & in_ready;

      // younger producer (S1, via ALU output) wins over S2
      s1_fwd_ok = s1_valid_q & s1_wr_en_q & (s1_opc_q != OPC_LW);
      s2_fwd_ok = s2_valid_q & s2_wr_en_q & (s2_opc_q != OPC_LW);

      rs1_op = io.in_rs1_val;
      if (io.in_rs1 != '0 && s1_fwd_ok && s1_rd_q == io.in_rs1)      rs1_op = io.alu_out;
      else if (io.in_rs1 != '0 && s2_fwd_ok && s2_rd_q == io.in_rs1) rs1_op = s2_result_q;

      rs2_op = io.in_rs2_val;
      if (io.in_rs2 != '0 && s1_fwd_ok && s1_rd_q == io.in_rs2)      rs2_op = io.alu_out;
      else if (io.in_rs2 != '0 && s2_fwd_ok && s2_rd_q == io.in_rs2) rs2_op = s2_result_q;

      legal_ops = (io.in_opc != OPC_JUMP) & (io.in_opc < OPC_ILL_MIN);

      s1_valid_d  = s1_valid_q;
      s1_opc_d    = s1_opc_q;
      s1_rd_d     = s1_rd_q;
      s1_wr_en_d  = s1_wr_en_q;
      s1_inp1_d   = s1_inp1_q;
      s1_inp2_d   = s1_inp2_q;
      s1_jmp_d    = s1_jmp_q;
      s1_store_d  = s1_store_q;
      s2_valid_d  = s2_valid_q;
      s2_opc_d    = s2_opc_q;
      s2_rd_d     = s2_rd_q;
      s2_wr_en_d  = s2_wr_en_q;
      s2_result_d = s2_result_q;
      s2_store_d  = s2_store_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_opc_d   = io.in_opc;
         s1_rd_d    = io.in_rd;
         s1_wr_en_d = writes_rd(io.in_opc) & (io.in_rd != '0);
         s1_inp1_d  = legal_ops ? rs1_op : '0;
         s1_inp2_d  = legal_ops ? (uses_imm(io.in_opc) ? io.in_imm : rs2_op) : '0;
         s1_jmp_d   = (io.in_opc == OPC_JUMP) ? io.in_imm : '0;
         s1_store_d = rs2_op;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         s2_valid_d  = 1'b1;
         s2_opc_d    = s1_opc_q;
         s2_rd_d     = s1_rd_q;
         s2_wr_en_d  = s1_wr_en_q;
         s2_store_d  = s1_store_q;
         if (s1_opc_q == OPC_JUMP)        s2_result_d = s1_jmp_q;
         else if (s1_opc_q >= OPC_ILL_MIN) s2_result_d = '0;
         else                              s2_result_d = io.alu_out;
      end else if (s2_adv) begin
         s2_valid_d = 1'b0;
      end
   end

   // pipeline registers; reset discards everything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_opc_q    <= '0;
         s1_rd_q     <= '0;
         s1_wr_en_q  <= 1'b0;
         s1_inp1_q   <= '0;
         s1_inp2_q   <= '0;
         s1_jmp_q    <= '0;
         s1_store_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_opc_q    <= '0;
         s2_rd_q     <= '0;
         s2_wr_en_q  <= 1'b0;
         s2_result_q <= '0;
         s2_store_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_opc_q    <= s1_opc_d;
         s1_rd_q     <= s1_rd_d;
         s1_wr_en_q  <= s1_wr_en_d;
         s1_inp1_q   <= s1_inp1_d;
         s1_inp2_q   <= s1_inp2_d;
         s1_jmp_q    <= s1_jmp_d;
         s1_store_q  <= s1_store_d;
         s2_valid_q  <= s2_valid_d;
         s2_opc_q    <= s2_opc_d;
         s2_rd_q     <= s2_rd_d;
         s2_wr_en_q  <= s2_wr_en_d;
         s2_result_q <= s2_result_d;
         s2_store_q  <= s2_store_d;
      end
   end

   assign io.in_ready       = in_ready;
   assign io.alu_inp1       = s1_inp1_q;
   assign io.alu_inp2       = s1_inp2_q;
   assign io.alu_opc        = s1_opc_q;
   assign io.out_valid      = s2_valid_q;
   assign io.out_opc        = s2_opc_q;
   assign io.out_rd         = s2_rd_q;
   assign io.out_wr_en      = s2_wr_en_q;
   assign io.out_result     = s2_result_q;
   assign io.out_store_data = s2_store_q;

endmodule
